// File: rtl/max7219_chain_driver.sv
// Serial driver for a daisy-chain of MAX7219 LED controllers: runs the power-up
// initialisation, then refreshes all digits on a ready/update handshake.
module max7219_chain_driver #(
  parameter int DEVICES = 1,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEVICES*64-1:0]  data,
  input  logic                   raw_mode,
  input  logic [3:0]             intensity,
  input  logic                   update,
  output logic                   ready,
  output logic                   spi_clk,
  output logic                   spi_do,
  output logic                   spi_cs
);
  localparam int B  = DEVICES * 16;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [6:0]    B_LAST = 7'(B - 1);

  localparam logic [1:0] M_INIT = 2'd0, M_IDLE = 2'd1, M_CFG = 2'd2, M_DIGITS = 2'd3;
  localparam logic [2:0] P_START = 3'd0, P_SHIFT = 3'd1, P_TAIL = 3'd2, P_GAP = 3'd3,
                         P_IDLE = 3'd4;

  logic [1:0]            mode;
  logic [2:0]            idx;
  logic [2:0]            phase;
  logic [HW-1:0]         hcnt;
  logic [6:0]            bcnt;
  logic [B-2:0]          sreg;
  logic                  need_dec, need_int;
  logic [DEVICES*64-1:0] snap_data;
  logic                  snap_raw, sent_raw;
  logic [3:0]            snap_int, sent_int;

  logic                  accept, gap_end, start, finish;
  logic [1:0]            nmode;
  logic [2:0]            nidx;
  logic                  use_raw, dec_pend, int_pend;
  logic [3:0]            use_int;
  logic [DEVICES*64-1:0] use_data;
  logic [3:0]            addr;
  logic [7:0]            val;
  logic [B-1:0]          word;

  // Next-frame selection; an accepted update starts its first frame on the same edge
  always_comb begin
    accept   = (phase == P_IDLE) && ready && update;
    gap_end  = (phase == P_GAP) && (hcnt == H_LAST);
    use_raw  = accept ? raw_mode  : snap_raw;
    use_int  = accept ? intensity : snap_int;
    use_data = accept ? data      : snap_data;
    dec_pend = accept ? (raw_mode != sent_raw)  : need_dec;
    int_pend = accept ? (intensity != sent_int) : need_int;
    start  = 1'b0;
    finish = 1'b0;
    nmode  = mode;
    nidx   = 3'd0;
    if (phase == P_START) begin
      start = 1'b1;
      nmode = M_INIT;
    end else if (accept) begin
      start = 1'b1;
      nmode = (dec_pend || int_pend) ? M_CFG : M_DIGITS;
    end else if (gap_end) begin
      case (mode)
        M_INIT:   if (idx != 3'd4) begin start = 1'b1; nidx = 3'(idx + 3'd1); end
                  else finish = 1'b1;
        M_CFG:    begin start = 1'b1; nmode = (dec_pend || int_pend) ? M_CFG : M_DIGITS; end
        M_DIGITS: if (idx != 3'd7) begin start = 1'b1; nidx = 3'(idx + 3'd1); end
                  else finish = 1'b1;
        default:  finish = 1'b1;
      endcase
    end
    addr = 4'h0;
    val  = 8'h00;
    case (nmode)
      M_INIT: begin
        case (nidx)
          3'd0:    begin addr = 4'hC; val = 8'h01; end
          3'd1:    begin addr = 4'hF; val = 8'h00; end
          3'd2:    begin addr = 4'hB; val = 8'h07; end
          3'd3:    begin addr = 4'h9; val = raw_mode ? 8'h00 : 8'hFF; end
          default: begin addr = 4'hA; val = {4'h0, intensity}; end
        endcase
      end
      M_CFG: begin
        if (dec_pend) begin addr = 4'h9; val = use_raw ? 8'h00 : 8'hFF; end
        else          begin addr = 4'hA; val = {4'h0, use_int}; end
      end
      default: addr = {1'b0, nidx} + 4'd1;
    endcase
    word = '0;
    for (int d = 0; d < DEVICES; d++)
      word[d*16 +: 16] = {4'h0, addr,
                          (nmode == M_DIGITS) ? use_data[d*64 + 8*int'(nidx) +: 8] : val};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= M_INIT;
      idx      <= 3'd0;
      phase    <= P_START;
      hcnt     <= '0;
      bcnt     <= 7'd0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_do   <= 1'b0;
      ready    <= 1'b0;
      need_dec <= 1'b0;
      need_int <= 1'b0;
    end else if (start) begin
      mode    <= nmode;
      idx     <= nidx;
      phase   <= P_SHIFT;
      hcnt    <= '0;
      bcnt    <= 7'd0;
      spi_cs  <= 1'b0;
      spi_clk <= 1'b0;
      spi_do  <= word[B-1];
      ready   <= 1'b0;
      if (nmode == M_CFG) begin
        need_dec <= 1'b0;
        need_int <= dec_pend && int_pend;
      end
    end else if (finish) begin
      mode  <= M_IDLE;
      phase <= P_IDLE;
      ready <= 1'b1;
    end else begin
      case (phase)
        P_SHIFT: begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              spi_clk <= 1'b0;
              if (bcnt == B_LAST) begin
                phase  <= P_TAIL;
                spi_do <= 1'b0;
              end else begin
                bcnt   <= bcnt + 7'd1;
                spi_do <= sreg[B-2];
              end
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        P_TAIL: begin
          if (hcnt == H_LAST) begin
            hcnt   <= '0;
            spi_cs <= 1'b1;
            phase  <= P_GAP;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        P_GAP:   hcnt <= hcnt + HW'(1);
        default: ;
      endcase
    end
  end

  // Datapath: shift register, update snapshot and last-sent configuration
  always_ff @(posedge clk) begin
    if (start)
      sreg <= word[B-2:0];
    else if (phase == P_SHIFT && hcnt == H_LAST && spi_clk)
      sreg <= {sreg[B-3:0], 1'b0};
    if (accept) begin
      snap_data <= data;
      snap_raw  <= raw_mode;
      snap_int  <= intensity;
      sent_raw  <= raw_mode;
      sent_int  <= intensity;
    end else if (finish && mode == M_INIT) begin
      sent_raw <= raw_mode;
      sent_int <= intensity;
    end
  end
endmodule

// File: tb/tb_max7219_chain_driver.sv
// Bench for max7219_chain_driver: single-device and two-device instances, serial
// frames decoded from the pins and compared with a frame-level reference model.
module tb_max7219_chain_driver;
  localparam int CD    = 4;
  localparam int LIMIT = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset1, raw1, upd1;
  logic [3:0]   int1;
  logic [63:0]  data1;
  logic         reset2, raw2, upd2;
  logic [3:0]   int2;
  logic [127:0] data2;
  wire  [1:0]   rdy, sclk, sdo, scs;

  max7219_chain_driver #(.DEVICES(1), .CLK_DIV(CD)) dut1 (
    .clk(clk), .reset(reset1), .data(data1), .raw_mode(raw1), .intensity(int1),
    .update(upd1), .ready(rdy[0]), .spi_clk(sclk[0]), .spi_do(sdo[0]), .spi_cs(scs[0]));

  max7219_chain_driver #(.DEVICES(2), .CLK_DIV(CD)) dut2 (
    .clk(clk), .reset(reset2), .data(data2), .raw_mode(raw2), .intensity(int2),
    .update(upd2), .ready(rdy[1]), .spi_clk(sclk[1]), .spi_do(sdo[1]), .spi_cs(scs[1]));

  typedef struct {
    int          nbits;
    logic [31:0] word;
    int          low;
  } frame_t;

  frame_t      mq0[$], mq1[$];
  int          mbits[2];
  int          mlow[2];
  logic [31:0] mword[2];
  logic        pcs[2] = '{1'b1, 1'b1};
  logic        pclk[2] = '{1'b0, 1'b0};

  // Pin-level frame decoder: bits are taken on spi_clk rising edges while CS is low
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (scs[i] === 1'b0 && pcs[i] === 1'b1) begin
        mbits[i] = 0; mword[i] = '0; mlow[i] = 0;
      end
      if (scs[i] === 1'b0) mlow[i]++;
      if (scs[i] === 1'b0 && sclk[i] === 1'b1 && pclk[i] === 1'b0) begin
        mword[i] = {mword[i][30:0], sdo[i]};
        mbits[i]++;
      end
      if (scs[i] === 1'b1 && pcs[i] === 1'b0) begin
        if (i == 0) mq0.push_back('{mbits[0], mword[0], mlow[0]});
        else        mq1.push_back('{mbits[1], mword[1], mlow[1]});
      end
      pcs[i]  = scs[i];
      pclk[i] = sclk[i];
    end
  end

  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic        m_raw[2];
  logic [3:0]  m_int[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rep(input int ndev, input logic [15:0] w);
    logic [31:0] r = '0;
    for (int d = 0; d < ndev; d++) r = (r << 16) | {16'h0, w};
    return r;
  endfunction

  task automatic model_init(input int i, input logic raw, input logic [3:0] inten);
    int n = i + 1;
    exp_q.delete();
    exp_q.push_back(rep(n, 16'h0C01));
    exp_q.push_back(rep(n, 16'h0F00));
    exp_q.push_back(rep(n, 16'h0B07));
    exp_q.push_back(rep(n, raw ? 16'h0900 : 16'h09FF));
    exp_q.push_back(rep(n, {12'h0A0, inten}));
    m_raw[i] = raw;
    m_int[i] = inten;
  endtask

  task automatic model_txn(input int i, input logic [127:0] d, input logic raw,
                           input logic [3:0] inten, output int ncfg);
    int n = i + 1;
    logic [31:0] w;
    exp_q.delete();
    ncfg = 0;
    if (raw != m_raw[i]) begin exp_q.push_back(rep(n, raw ? 16'h0900 : 16'h09FF)); ncfg++; end
    if (inten != m_int[i]) begin exp_q.push_back(rep(n, {12'h0A0, inten})); ncfg++; end
    m_raw[i] = raw;
    m_int[i] = inten;
    for (int k = 0; k < 8; k++) begin
      w = '0;
      for (int dv = n - 1; dv >= 0; dv--)
        w = (w << 16) | {16'h0, 4'h0, 4'(k + 1), d[dv*64 + k*8 +: 8]};
      exp_q.push_back(w);
    end
  endtask

  // Counts cycles with ready low; optionally pokes new inputs and an ignored update mid-way
  task automatic wait_ready(input int i, input bit disturb, output int cnt);
    cnt = 0;
    while (rdy[i] !== 1'b1 && cnt < LIMIT) begin
      cnt++;
      if (disturb && cnt == 200) begin
        data1 = {$urandom, $urandom}; raw1 = ~raw1; int1 = int1 + 4'd3; upd1 = 1'b1;
      end
      if (disturb && cnt == 201) upd1 = 1'b0;
      @(negedge clk);
    end
    check("ready_within_bound", 64'(cnt < LIMIT), 64'd1);
  endtask

  task automatic check_frames(input int i, input string tag);
    frame_t g;
    int n, b;
    b = 16 * (i + 1);
    n = (i == 0) ? mq0.size() : mq1.size();
    check({tag, " frame_count"}, 64'(n), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      g = (i == 0) ? mq0[k] : mq1[k];
      check($sformatf("%s frame%0d word", tag, k), 64'(g.word), 64'(exp_q[k]));
      check($sformatf("%s frame%0d bits", tag, k), 64'(g.nbits), 64'(b));
      check($sformatf("%s frame%0d cs_low", tag, k), 64'(g.low), 64'((2*b + 1) * CD));
    end
  endtask

  task automatic run_init(input int i, input string tag);
    int cnt, b;
    b = 16 * (i + 1);
    if (i == 0) begin model_init(0, raw1, int1); mq0.delete(); reset1 = 1'b0; end
    else        begin model_init(1, raw2, int2); mq1.delete(); reset2 = 1'b0; end
    @(negedge clk);
    check({tag, " first_cs"}, 64'(scs[i]), 64'd0);
    check({tag, " first_msb"}, 64'(sdo[i]), 64'd0);
    wait_ready(i, 1'b0, cnt);
    check({tag, " init_cycles"}, 64'(cnt), 64'(5 * (2*b + 2) * CD));
    check_frames(i, tag);
  endtask

  task automatic run_txn(input int i, input logic [127:0] d, input logic raw,
                         input logic [3:0] inten, input bit disturb, input string tag,
                         output int nfr, output logic [31:0] first);
    int ncfg, cnt, b;
    b = 16 * (i + 1);
    model_txn(i, d, raw, inten, ncfg);
    if (i == 0) begin
      mq0.delete(); data1 = d[63:0]; raw1 = raw; int1 = inten; upd1 = 1'b1;
    end else begin
      mq1.delete(); data2 = d; raw2 = raw; int2 = inten; upd2 = 1'b1;
    end
    @(negedge clk);
    upd1 = 1'b0;
    upd2 = 1'b0;
    check({tag, " cs_latency"}, 64'(scs[i]), 64'd0);
    wait_ready(i, disturb, cnt);
    check({tag, " ready_low"}, 64'(cnt), 64'((8 + ncfg) * (2*b + 2) * CD));
    check_frames(i, tag);
    nfr   = (i == 0) ? mq0.size() : mq1.size();
    first = (nfr > 0) ? ((i == 0) ? mq0[0].word : mq1[0].word) : 32'h0;
  endtask

  typedef struct {
    logic [63:0] data;
    logic        raw;
    logic [3:0]  inten;
    bit          disturb;
    int          exp_frames;
    logic [15:0] exp_first;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    int          nfr, guard;
    logic [31:0] first;
    logic [63:0] rd;

    tbl[0] = '{64'h0706050403020100, 1'b0, 4'd7,  1'b0, 8,  16'h0100};
    tbl[1] = '{64'hFFEEDDCCBBAA9988, 1'b0, 4'd15, 1'b1, 9,  16'h0A0F};
    tbl[2] = '{64'h123456789ABCDEF0, 1'b1, 4'd15, 1'b0, 9,  16'h0900};
    tbl[3] = '{64'h8877665544332211, 1'b1, 4'd15, 1'b1, 8,  16'h0111};
    tbl[4] = '{64'h0F1E2D3C4B5A6978, 1'b0, 4'd2,  1'b0, 10, 16'h09FF};

    reset1 = 1'b1; raw1 = 1'b0; int1 = 4'd7; data1 = '0; upd1 = 1'b0;
    reset2 = 1'b1; raw2 = 1'b0; int2 = 4'd7; data2 = '0; upd2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cs",    64'(scs[0]),  64'd1);
    check("reset clk",   64'(sclk[0]), 64'd0);
    check("reset do",    64'(sdo[0]),  64'd0);
    check("reset ready", 64'(rdy[0]),  64'd0);

    run_init(0, "init");

    for (int t = 0; t < 5; t++) begin
      run_txn(0, {64'h0, tbl[t].data}, tbl[t].raw, tbl[t].inten, tbl[t].disturb,
              $sformatf("vec%0d", t), nfr, first);
      check($sformatf("vec%0d nframes", t), 64'(nfr), 64'(tbl[t].exp_frames));
      check($sformatf("vec%0d first", t), 64'(first), 64'(tbl[t].exp_first));
    end

    for (int t = 0; t < 4; t++) begin
      rd = {$urandom, $urandom};
      run_txn(0, {64'h0, rd}, 1'($urandom_range(1)), 4'($urandom_range(15)),
              1'($urandom_range(1)), $sformatf("rnd%0d", t), nfr, first);
    end

    // Abort a digit frame part-way and expect a clean restart of INIT
    data1 = {$urandom, $urandom}; raw1 = m_raw[0]; int1 = m_int[0]; upd1 = 1'b1;
    @(negedge clk);
    upd1 = 1'b0;
    guard = 0;
    while (mbits[0] < 9 && guard < 500) begin guard++; @(negedge clk); end
    check("abort reached_bit9", 64'(guard < 500), 64'd1);
    reset1 = 1'b1;
    @(negedge clk);
    check("abort cs",    64'(scs[0]),  64'd1);
    check("abort clk",   64'(sclk[0]), 64'd0);
    check("abort do",    64'(sdo[0]),  64'd0);
    check("abort ready", 64'(rdy[0]),  64'd0);
    repeat (3) @(negedge clk);
    run_init(0, "reinit");
    run_txn(0, {64'h0, 64'h0706050403020100}, raw1, int1, 1'b0, "post_reinit", nfr, first);
    check("post_reinit first", 64'(first), 64'h0100);

    check("chain reset cs", 64'(scs[1]), 64'd1);
    run_init(1, "chain_init");
    run_txn(1, {{8{8'h22}}, {8{8'h11}}}, 1'b0, 4'd7, 1'b0, "chain", nfr, first);
    check("chain first", 64'(first), 64'h01220111);
    run_txn(1, {{8{8'hA5}}, {8{8'h3C}}}, 1'b0, 4'd15, 1'b0, "chain_cfg", nfr, first);
    check("chain_cfg first", 64'(first), 64'h0A0F0A0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
